// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the data memory write port and read port 1
// between the core load/store path (r0) and the loader (r1).
//
// state  | meaning
// IDLE   | waiting for a request; winner sees ready combinationally
// ACCESS | single memory cycle: write strobe or read address presented
// RESP   | rvalid pulse to the requester that issued the read
module mem_port_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_valid,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_ready,
   output logic              r0_rvalid,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_valid,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_ready,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              mem_write_enable,
   output logic [ADDR_W-1:0] write_address,
   output logic [DATA_W-1:0] write_data,
   output logic [ADDR_W-1:0] read_address1,
   input  logic [DATA_W-1:0] read_data1
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state;
   logic                last_grant;
   logic                cur_id;
   logic                cur_we;
   logic                write_strobe;
   logic                grant_id;
   logic                handshake;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   // On a tie the requester that did not win last time is served.
   always_comb begin
      grant_id = 1'b0;
      if (r0_valid && r1_valid) grant_id = ~last_grant;
      else                      grant_id = r1_valid;
   end

   always_comb begin
      sel_we    = r0_we;
      sel_addr  = r0_addr;
      sel_wdata = r0_wdata;
      if (grant_id) begin
         sel_we    = r1_we;
         sel_addr  = r1_addr;
         sel_wdata = r1_wdata;
      end
   end

   assign r0_ready  = rst_n && (state == IDLE) && r0_valid && !grant_id;
   assign r1_ready  = rst_n && (state == IDLE) && r1_valid &&  grant_id;
   assign handshake = r0_ready || r1_ready;

   // A reset asserted during ACCESS must keep the pending write out of memory.
   assign mem_write_enable = write_strobe && rst_n;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         cur_id        <= 1'b0;
         cur_we        <= 1'b0;
         write_strobe  <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
         read_address1 <= '0;
         r0_rvalid     <= 1'b0;
         r1_rvalid     <= 1'b0;
         r0_rdata      <= '0;
         r1_rdata      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  cur_id        <= grant_id;
                  cur_we        <= sel_we;
                  last_grant    <= grant_id;
                  write_strobe  <= sel_we;
                  write_address <= sel_addr;
                  write_data    <= sel_wdata;
                  read_address1 <= sel_addr;
                  state         <= ACCESS;
               end
            end
            ACCESS: begin
               write_strobe <= 1'b0;
               if (cur_we) begin
                  state <= IDLE;
               end else begin
                  if (cur_id) begin
                     r1_rdata  <= read_data1;
                     r1_rvalid <= 1'b1;
                  end else begin
                     r0_rdata  <= read_data1;
                     r0_rvalid <= 1'b1;
                  end
                  state <= RESP;
               end
            end
            RESP: begin
               r0_rvalid <= 1'b0;
               r1_rvalid <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               write_strobe <= 1'b0;
               r0_rvalid    <= 1'b0;
               r1_rvalid    <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 64x32 behavioural memory model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        r0_valid, r0_we, r0_ready, r0_rvalid;
   logic [5:0]  r0_addr;
   logic [31:0] r0_wdata, r0_rdata;
   logic        r1_valid, r1_we, r1_ready, r1_rvalid;
   logic [5:0]  r1_addr;
   logic [31:0] r1_wdata, r1_rdata;
   logic        mem_write_enable;
   logic [5:0]  write_address, read_address1;
   logic [31:0] write_data, read_data1;

   logic [31:0] mem [64];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (mem_write_enable) mem[write_address] <= write_data;
   assign read_data1 = mem[read_address1];

   mem_port_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
      .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
      .mem_write_enable(mem_write_enable), .write_address(write_address),
      .write_data(write_data), .read_address1(read_address1), .read_data1(read_data1)
   );

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [147:0] outs;
      @(negedge clk);
      rst_n = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1;
      r0_we = 1'b1; r1_we = 1'b1; r0_addr = 6'd7; r1_addr = 6'd9;
      r0_wdata = 32'h1111; r1_wdata = 32'h2222;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         outs = {r0_ready, r1_ready, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
                 mem_write_enable, write_address, write_data, read_address1};
         n_cmp++;
         if (outs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs cycle %0d got %h expected 0", i, outs);
         end
      end
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if ({r0_ready, r1_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL reset_first_tie got r0/r1 ready %b expected 10", {r0_ready, r1_ready});
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
   endtask

   task automatic test_write_read();
      @(negedge clk);
      r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 6'd0; r0_wdata = 32'h5;
      #1;
      n_cmp++;
      if (r0_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready got %b expected 1", r0_ready); end
      @(posedge clk);
      @(negedge clk);
      r0_valid = 1'b0;
      #1;
      n_cmp++;
      if ({mem_write_enable, write_address, write_data} !== {1'b1, 6'd0, 32'h5}) begin
         n_err++;
         $display("FAIL wr_access got we=%b a=%0d d=%h expected we=1 a=0 d=5",
                  mem_write_enable, write_address, write_data);
      end
      @(negedge clk);
      r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 6'd0;
      #1;
      n_cmp++;
      if ({mem_write_enable, mem[0]} !== {1'b0, 32'h5}) begin
         n_err++;
         $display("FAIL wr_done got we=%b mem0=%h expected we=0 mem0=5", mem_write_enable, mem[0]);
      end
      n_cmp++;
      if (r0_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready got %b expected 1", r0_ready); end
      @(posedge clk);
      @(negedge clk);
      r0_valid = 1'b0;
      #1;
      n_cmp++;
      if ({r0_rvalid, read_address1, mem_write_enable} !== {1'b0, 6'd0, 1'b0}) begin
         n_err++;
         $display("FAIL rd_access got rvalid=%b ra=%0d we=%b expected 0 0 0",
                  r0_rvalid, read_address1, mem_write_enable);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({r0_rvalid, r1_rvalid, r0_rdata} !== {1'b1, 1'b0, 32'h5}) begin
         n_err++;
         $display("FAIL rd_resp got rv0=%b rv1=%b d=%h expected 1 0 5", r0_rvalid, r1_rvalid, r0_rdata);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({r0_rvalid, r0_rdata} !== {1'b0, 32'h5}) begin
         n_err++;
         $display("FAIL rd_pulse_end got rv0=%b d=%h expected 0 5", r0_rvalid, r0_rdata);
      end
   endtask

   task automatic test_round_robin();
      int grants = 0;
      int rvs = 0;
      int last = -1;
      bit done = 0;
      do_reset();
      r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 6'd1; r0_wdata = 32'h9;
      r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 6'd1; r1_wdata = 32'h0;
      for (int i = 0; i < 30 && !done; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (r0_ready || r1_ready) begin
            n_cmp++;
            if ((r0_ready && r1_ready) || (r1_ready ? 1 : 0) != (grants % 2) || last == (r1_ready ? 1 : 0)) begin
               n_err++;
               $display("FAIL rr_grant %0d got r0=%b r1=%b expected r%0d", grants, r0_ready, r1_ready, grants % 2);
            end
            last = r1_ready ? 1 : 0;
            grants++;
         end
         if (r1_rvalid) begin
            rvs++;
            n_cmp++;
            if (r1_rdata !== 32'h9) begin
               n_err++;
               $display("FAIL rr_rdata got %h expected 00000009", r1_rdata);
            end
         end
         if (r0_rvalid) begin
            n_cmp++; n_err++;
            $display("FAIL rr_r0_rvalid got 1 expected 0");
         end
         if (grants == 4 && rvs == 2) done = 1;
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      n_cmp++;
      if (!done) begin n_err++; $display("FAIL rr_timeout got grants=%0d rvalids=%0d expected 4 2", grants, rvs); end
   endtask

   task automatic test_r1_only();
      @(negedge clk);
      r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 6'd63;
      #1;
      n_cmp++;
      if ({r0_ready, r1_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL r1only_ready got %b expected 01", {r0_ready, r1_ready});
      end
      @(posedge clk);
      @(negedge clk);
      r1_valid = 1'b0;
      @(negedge clk);
      #1;
      n_cmp++;
      if ({r1_rvalid, r0_rvalid, r1_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
         n_err++;
         $display("FAIL r1only_resp got rv1=%b rv0=%b d=%h expected 1 0 deadbeef", r1_rvalid, r0_rvalid, r1_rdata);
      end
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 6'd2; r0_wdata = 32'hA;
      r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 6'd2;
      #1;
      n_cmp++;
      if ({r0_ready, r1_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL abort_grant got %b expected 10", {r0_ready, r1_ready});
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if ({mem_write_enable, r0_rvalid, r1_rvalid, mem[2]} !== {3'b000, 32'h0}) begin
         n_err++;
         $display("FAIL abort_state got we=%b rv0=%b rv1=%b mem2=%h expected 0 0 0 0",
                  mem_write_enable, r0_rvalid, r1_rvalid, mem[2]);
      end
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if ({r0_ready, r1_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL abort_next_tie got %b expected 10", {r0_ready, r1_ready});
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int t0 = 0;
      int t1 = 0;
      bit got = 0;
      bit seen = 0;
      @(negedge clk);
      r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 6'd0;
      #1;
      t0 = cyc;
      n_cmp++;
      if (r0_ready !== 1'b1) begin n_err++; $display("FAIL b2b_first_ready got %b expected 1", r0_ready); end
      @(posedge clk);
      @(negedge clk);
      r0_addr = 6'd1;
      for (int i = 0; i < 8 && !got; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if (r0_rvalid) begin
            seen = 1;
            n_cmp++;
            if (r0_rdata !== 32'h5) begin n_err++; $display("FAIL b2b_rdata0 got %h expected 00000005", r0_rdata); end
         end
         if (r0_ready) begin got = 1; t1 = cyc; end
      end
      n_cmp++;
      if (!got || !seen || (t1 - t0) != 3) begin
         n_err++;
         $display("FAIL b2b_spacing got ready=%b rvalid=%b gap=%0d expected 1 1 3", got, seen, t1 - t0);
      end
      @(posedge clk);
      @(negedge clk);
      r0_valid = 1'b0;
      @(negedge clk);
      #1;
      n_cmp++;
      if ({r0_rvalid, r0_rdata} !== {1'b1, 32'h9}) begin
         n_err++;
         $display("FAIL b2b_rdata1 got rv=%b d=%h expected 1 00000009", r0_rvalid, r0_rdata);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[63] = 32'hDEADBEEF;
      rst_n = 1'b0;
      r0_valid = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
      r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
      test_reset();
      test_write_read();
      test_round_robin();
      test_r1_only();
      test_reset_mid_access();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
